// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer that pulses the CPU interrupt.
// Optional prescaler (PRESC register) built when IRQ_TIMER_PRESCALE_EN is defined.
module irq_timer #(
  parameter int              SIZE      = 14,
  parameter logic [SIZE-1:0] BASE_ADDR = 14'h3FF0,
  parameter int              CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     rd_data,
  output logic            rd_hit,
  output logic            interrupt
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t           state;
  logic             en;
  logic             auto_rl;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;
  logic             pend;
  logic [7:0]       missed;
  logic             tick;
  logic [7:0]       presc_rd;

  // Window decode: addresses below BASE_ADDR wrap to a large offset.
  logic [SIZE:0] rel;
  logic          in_win;
  logic [2:0]    off;
  logic          wr_ctrl;
  logic          wr_load;
  logic          wr_stat;
  logic          clr_stat;

  assign rel      = {1'b0, addr_toRAM} - {1'b0, BASE_ADDR};
  assign in_win   = (rel < (SIZE+1)'(8));
  assign off      = rel[2:0];
  assign wr_ctrl  = wrEn && in_win && (off == 3'd0);
  assign wr_load  = wrEn && in_win && (off == 3'd1);
  assign wr_stat  = wrEn && in_win && (off == 3'd3);
  assign clr_stat = wr_stat && data_toRAM[0];

`ifdef IRQ_TIMER_PRESCALE_EN
  logic [7:0] presc;
  logic [7:0] psc_cnt;
  logic       wr_presc;

  assign wr_presc = wrEn && in_win && (off == 3'd4);
  assign tick     = (psc_cnt == presc);
  assign presc_rd = presc;

  // Prescaler register write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (wr_presc) begin
      presc <= data_toRAM[7:0];
    end
  end

  // Prescale counter: restarts on every arm, wraps on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
    end else if (state == ARM) begin
      psc_cnt <= '0;
    end else if (state == RUN) begin
      psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick     = 1'b1;
  assign presc_rd = 8'd0;
`endif

  // Reload value register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load <= '0;
    end else if (wr_load) begin
      load <= CNT_W'(data_toRAM);
    end
  end

  // Timer FSM with control, count, status and interrupt pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      count     <= '0;
      pend      <= 1'b0;
      missed    <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      if (wr_ctrl) begin
        en      <= data_toRAM[0];
        auto_rl <= data_toRAM[1];
      end
      if (clr_stat) begin
        pend   <= 1'b0;
        missed <= '0;
      end
      unique case (state)
        IDLE: begin
          if (wr_ctrl && data_toRAM[0]) state <= ARM;
        end
        ARM: begin
          if (wr_ctrl) begin
            state <= data_toRAM[0] ? ARM : IDLE;
          end else begin
            count <= load;
            state <= RUN;
          end
        end
        RUN: begin
          if (wr_ctrl) begin
            state <= data_toRAM[0] ? ARM : IDLE;
          end else if (tick) begin
            if (count != '0) begin
              count <= count - CNT_W'(1);
            end else begin
              // Expiry: a same-cycle clear still leaves PEND set
              interrupt <= 1'b1;
              pend      <= 1'b1;
              if (!clr_stat && pend && (missed != 8'hFF))
                missed <= missed + 8'd1;
              if (auto_rl) begin
                count <= load;
              end else begin
                en    <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] rd_mux;

  // Register read mux on current (pre-write) values
  always_comb begin
    rd_mux = '0;
    unique case (off)
      3'd0:    rd_mux = {30'd0, auto_rl, en};
      3'd1:    rd_mux = 32'(load);
      3'd2:    rd_mux = 32'(count);
      3'd3:    rd_mux = {16'd0, missed, 7'd0, pend};
      3'd4:    rd_mux = {24'd0, presc_rd};
      default: rd_mux = '0;
    endcase
  end

  // Registered read port, one cycle behind the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      rd_hit  <= in_win;
      rd_data <= in_win ? rd_mux : 32'd0;
    end
  end

endmodule
